key_matrix_scan_ctrl: RTL and testbench

Scan controller for a 4x4 active-low matrix keypad. It drives one row low at a time, samples the synchronised column lines and debounces whole-scan snapshots. It emits one-cycle press, auto-repeat and release events with a 4-bit key code. It sits between the keypad pins and the UI/mode logic, alongside the single-key debouncers, and serves the same consumers.

---
 rtl/key_matrix_scan_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_key_matrix_scan_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/key_matrix_scan_ctrl.sv
// 4x4 active-low keypad scanner: row drive, column sync, whole-scan debounce, press/repeat/release events.
// Latency: key_vld/key_rel assert 2 sclk after the row-3 sample of the confirming scan.
// Backpressure: none; events are single-cycle pulses that the consumer must take when they appear.
module key_matrix_scan_ctrl #(
  parameter int SCAN_DIV  = 49999,
  parameter int DEB_SCANS = 5,
  parameter int REP_DLY   = 125,
  parameter int REP_PER   = 25
) (
  input  logic       sclk,
  input  logic       s_rst_n,
  input  logic [3:0] col_in,
  input  logic       rep_en,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_vld,
  output logic       key_rel,
  output logic       key_down
);

  localparam logic [15:0] DIV_W = 16'(SCAN_DIV);
  localparam logic [3:0]  DEB_W = 4'(DEB_SCANS);
  localparam logic [9:0]  DLY_W = 10'(REP_DLY);
  localparam logic [9:0]  PER_W = 10'(REP_PER);

  // Scan result classes; code is forced to 0 for NONE/MULTI so equality compares cleanly.
  localparam logic [1:0] K_NONE   = 2'd0;
  localparam logic [1:0] K_SINGLE = 2'd1;
  localparam logic [1:0] K_MULTI  = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_REPEAT} state_e;

  logic [3:0]  col_s1_q, col_s2_q;
  logic [15:0] dwell_q, dwell_d;
  logic [1:0]  row_q;
  logic [15:0] snap_q;
  logic        scan_done_q;
  logic        sample_en;

  logic [4:0]  n_set;
  logic [3:0]  bit_code;
  logic [1:0]  cls_kind;
  logic [3:0]  cls_code;

  logic [1:0]  prev_kind_q;
  logic [3:0]  prev_code_q;
  logic [3:0]  stab_q;
  logic        bnd_q, conf_q;

  state_e      state_q, state_d;
  logic [9:0]  rep_cnt_q, rep_cnt_d, rep_inc;
  logic [3:0]  key_code_q, key_code_d;
  logic        key_vld_q, key_vld_d;
  logic        key_rel_q, key_rel_d;
  logic        key_down_q, key_down_d;

  logic        press_ev, rel_ev, same_key, dly_hit, per_hit;

  // Two-flop synchroniser for the asynchronous column pins; idle level is all-high.
  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      col_s1_q <= 4'hF;
      col_s2_q <= 4'hF;
    end else begin
      col_s1_q <= col_in;
      col_s2_q <= col_s1_q;
    end
  end

  assign sample_en = (dwell_q == DIV_W);
  assign dwell_d   = sample_en ? 16'd0 : dwell_q + 16'd1;

  // Dwell timer, row pointer and snapshot capture at the last cycle of each dwell.
  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      dwell_q     <= 16'd0;
      row_q       <= 2'd0;
      snap_q      <= 16'd0;
      scan_done_q <= 1'b0;
    end else begin
      dwell_q     <= dwell_d;
      scan_done_q <= sample_en && (row_q == 2'd3);
      if (sample_en) begin
        row_q                       <= row_q + 2'd1;
        snap_q[{row_q, 2'b00} +: 4] <= ~col_s2_q;
      end
    end
  end

  assign row_out = ~(4'b0001 << row_q);

  // Classify the completed snapshot into NONE / SINGLE(code) / MULTI.
  always_comb begin
    n_set    = 5'd0;
    bit_code = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (snap_q[i]) begin
        n_set    = n_set + 5'd1;
        bit_code = 4'(i);
      end
    end
    cls_kind = K_MULTI;
    cls_code = 4'd0;
    if (n_set == 5'd0) begin
      cls_kind = K_NONE;
    end else if (n_set == 5'd1) begin
      cls_kind = K_SINGLE;
      cls_code = bit_code;
    end
  end

  // Debounce: count identical consecutive scans; confirm exactly once when the run reaches DEB_SCANS.
  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      prev_kind_q <= K_NONE;
      prev_code_q <= 4'd0;
      stab_q      <= 4'd0;
      bnd_q       <= 1'b0;
      conf_q      <= 1'b0;
    end else begin
      bnd_q  <= scan_done_q;
      conf_q <= 1'b0;
      if (scan_done_q) begin
        if (cls_kind == prev_kind_q && cls_code == prev_code_q) begin
          if (stab_q < DEB_W) begin
            stab_q <= stab_q + 4'd1;
            conf_q <= ((stab_q + 4'd1) == DEB_W);
          end
        end else begin
          prev_kind_q <= cls_kind;
          prev_code_q <= cls_code;
          stab_q      <= 4'd1;
          conf_q      <= (DEB_W == 4'd1);
        end
      end
    end
  end

  // prev_* always holds the result of the scan just classified once bnd_q is high.
  assign press_ev = bnd_q && conf_q && (prev_kind_q == K_SINGLE);
  assign rel_ev   = bnd_q && conf_q && (prev_kind_q == K_NONE);
  assign same_key = bnd_q && (prev_kind_q == K_SINGLE) && (prev_code_q == key_code_q);
  assign rep_inc  = (rep_cnt_q == 10'h3FF) ? rep_cnt_q : rep_cnt_q + 10'd1;
  assign dly_hit  = rep_en && (rep_inc >= DLY_W);
  assign per_hit  = rep_inc >= PER_W;

  // State and event/output registers.
  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      state_q    <= S_IDLE;
      rep_cnt_q  <= 10'd0;
      key_code_q <= 4'd0;
      key_vld_q  <= 1'b0;
      key_rel_q  <= 1'b0;
      key_down_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rep_cnt_q  <= rep_cnt_d;
      key_code_q <= key_code_d;
      key_vld_q  <= key_vld_d;
      key_rel_q  <= key_rel_d;
      key_down_q <= key_down_d;
    end
  end

  // Next state: a press needs IDLE; only a confirmed NONE leaves PRESSED/REPEAT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (press_ev) state_d = S_PRESSED;
      S_PRESSED: begin
        if (rel_ev)                   state_d = S_IDLE;
        else if (same_key && dly_hit) state_d = S_REPEAT;
      end
      S_REPEAT:  if (rel_ev) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Event generation and repeat counting; release wins over repeat in the same boundary.
  always_comb begin
    key_vld_d  = 1'b0;
    key_rel_d  = 1'b0;
    key_down_d = key_down_q;
    key_code_d = key_code_q;
    rep_cnt_d  = rep_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (press_ev) begin
          key_vld_d  = 1'b1;
          key_down_d = 1'b1;
          key_code_d = prev_code_q;
          rep_cnt_d  = 10'd0;
        end
      end
      S_PRESSED: begin
        if (rel_ev) begin
          key_rel_d  = 1'b1;
          key_down_d = 1'b0;
        end else if (same_key) begin
          if (dly_hit) begin
            key_vld_d = 1'b1;
            rep_cnt_d = 10'd0;
          end else begin
            rep_cnt_d = rep_inc;
          end
        end
      end
      S_REPEAT: begin
        if (rel_ev) begin
          key_rel_d  = 1'b1;
          key_down_d = 1'b0;
        end else if (same_key && rep_en) begin
          if (per_hit) begin
            key_vld_d = 1'b1;
            rep_cnt_d = 10'd0;
          end else begin
            rep_cnt_d = rep_inc;
          end
        end
      end
      default: key_down_d = 1'b0;
    endcase
  end

  assign key_code = key_code_q;
  assign key_vld  = key_vld_q;
  assign key_rel  = key_rel_q;
  assign key_down = key_down_q;

endmodule

// File: tb/tb_key_matrix_scan_ctrl.sv
// Directed bench for key_matrix_scan_ctrl with 16-cycle scans (SCAN_DIV=3, DEB_SCANS=3, REP_DLY=4, REP_PER=2).
// A scan boundary (row-3 sample) lands on edge 16*m after reset release; events appear at edge 16*m+2.
// Key states change just after a boundary edge so the next scan sees them on every row.
module tb_key_matrix_scan_ctrl;

  logic       sclk = 1'b0;
  logic       s_rst_n;
  logic [3:0] col_in;
  logic       rep_en;
  logic [3:0] row_out;
  logic [3:0] key_code;
  logic       key_vld;
  logic       key_rel;
  logic       key_down;

  logic [15:0] keys;
  int          cyc;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          vld_cyc[$];
  int          vld_code[$];
  int          rel_cyc[$];

  key_matrix_scan_ctrl #(
    .SCAN_DIV (3),
    .DEB_SCANS(3),
    .REP_DLY  (4),
    .REP_PER  (2)
  ) dut (
    .sclk    (sclk),
    .s_rst_n (s_rst_n),
    .col_in  (col_in),
    .rep_en  (rep_en),
    .row_out (row_out),
    .key_code(key_code),
    .key_vld (key_vld),
    .key_rel (key_rel),
    .key_down(key_down)
  );

  always #5 sclk = ~sclk;

  // Keypad: a pressed key shorts its column to its row, so a low row pulls that column low.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
  end

  // Edge counter since reset release.
  always @(posedge sclk) begin
    if (!s_rst_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Event log, sampled away from the active edge.
  always @(negedge sclk) begin
    if (s_rst_n === 1'b1) begin
      if (key_vld) begin
        vld_cyc.push_back(cyc);
        vld_code.push_back(int'(key_code));
      end
      if (key_rel) rel_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge sclk);
  endtask

  function automatic int vld_at(input int i);
    return (i < vld_cyc.size()) ? vld_cyc[i] : -1;
  endfunction

  function automatic int code_at(input int i);
    return (i < vld_code.size()) ? vld_code[i] : -1;
  endfunction

  function automatic int rel_at(input int i);
    return (i < rel_cyc.size()) ? rel_cyc[i] : -1;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rep_exp[5];
    rep_exp = '{626, 658, 690, 722, 754};

    s_rst_n = 1'b0;
    keys    = 16'h0;
    rep_en  = 1'b1;
    repeat (3) @(negedge sclk);
    check("rst_row", int'(row_out), 4'b1110);
    check("rst_code", int'(key_code), 0);
    check("rst_vld_rel_down", int'({key_vld, key_rel, key_down}), 0);
    s_rst_n = 1'b1;

    // Row rotation, 4 cycles per row.
    wait_cyc(3);  check("row0_hold", int'(row_out), 4'b1110);
    wait_cyc(4);  check("row1", int'(row_out), 4'b1101);
    wait_cyc(8);  check("row2", int'(row_out), 4'b1011);
    wait_cyc(12); check("row3", int'(row_out), 4'b0111);
    wait_cyc(16); check("row_wrap", int'(row_out), 4'b1110);

    // Idle keypad for 500 cycles: no events.
    wait_cyc(500);
    check("idle_vld_cnt", vld_cyc.size(), 0);
    check("idle_rel_cnt", rel_cyc.size(), 0);

    // Press key 9 (row2/col1) at scan 32: confirmed at boundary 35.
    wait_cyc(512); keys[9] = 1'b1;
    wait_cyc(570);
    check("press9_cyc", vld_at(0), 562);
    check("press9_code", code_at(0), 9);
    check("press9_down", int'(key_down), 1);

    // Repeats at boundaries 39,41,43,45,47; then rep_en=0 freezes repeats.
    wait_cyc(760);
    rep_en = 1'b0;
    for (int i = 0; i < 5; i++) check($sformatf("rep%0d_cyc", i), vld_at(i + 1), rep_exp[i]);

    // Release at scan 53: confirmed NONE at boundary 56.
    wait_cyc(848); keys = 16'h0;
    wait_cyc(900);
    check("rep_off_vld_cnt", vld_cyc.size(), 6);
    check("rel9_cyc", rel_at(0), 898);
    check("rel9_down", int'(key_down), 0);
    check("rel9_code_kept", int'(key_code), 9);

    // Chatter on key 6 for 10 scans, then hold from scan 70: confirmed at boundary 73.
    for (int s = 60; s < 70; s++) begin
      wait_cyc(16 * s);
      keys[6] = ((s - 60) % 2 == 0);
    end
    wait_cyc(1120); keys[6] = 1'b1;
    wait_cyc(1160);
    check("chatter_vld_cnt", vld_cyc.size(), 6);
    wait_cyc(1180);
    check("hold6_cyc", vld_at(6), 1170);
    check("hold6_code", code_at(6), 6);
    wait_cyc(1184); keys = 16'h0;
    wait_cyc(1240);
    check("rel6_cyc", rel_at(1), 1234);

    // Keys 0 and 5 together from IDLE: MULTI is ignored.
    wait_cyc(1280); keys = 16'h0021;
    wait_cyc(1376); keys = 16'h0;
    wait_cyc(1436);
    check("multi_vld_cnt", vld_cyc.size(), 7);
    check("multi_rel_cnt", rel_cyc.size(), 2);
    check("multi_down", int'(key_down), 0);

    // Key 3 pressed, key 7 added: no new press, repeat suppressed, one release.
    wait_cyc(1440); keys = 16'h0008; rep_en = 1'b1;
    wait_cyc(1504); keys = 16'h0088;
    wait_cyc(1660);
    check("k3_cyc", vld_at(7), 1490);
    check("k3_code", code_at(7), 3);
    check("k3k7_vld_cnt", vld_cyc.size(), 8);
    check("k3k7_down", int'(key_down), 1);
    wait_cyc(1664); keys = 16'h0;
    wait_cyc(1720);
    check("k3k7_rel_cyc", rel_at(2), 1714);
    check("k3k7_rel_cnt", rel_cyc.size(), 3);
    check("k3k7_vld_cnt_end", vld_cyc.size(), 8);

    // Reset mid row 2 while key 9 is held.
    wait_cyc(1760); keys[9] = 1'b1; rep_en = 1'b0;
    wait_cyc(1833);
    check("pre_rst_row2", int'(row_out), 4'b1011);
    check("pre_rst_down", int'(key_down), 1);
    check("pre_rst_code", int'(key_code), 9);
    s_rst_n = 1'b0;
    @(negedge sclk);
    check("mid_rst_row", int'(row_out), 4'b1110);
    check("mid_rst_code", int'(key_code), 0);
    check("mid_rst_vld_rel_down", int'({key_vld, key_rel, key_down}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
